// File: rtl/ariane_shadow_spill_if.sv
// Memory request/response channel between the shadow spill engine (master) and the data memory port (slave).
interface ariane_shadow_spill_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ariane_shadow_spill.sv
// Spills the 16-entry shadow integer bank to the interrupt stack frame and restores it on mret.
// Restore path (RLOAD/RWAIT/SPFIX, regfile write port) is built only when SHADOW_RESTORE_EN is defined.
module ariane_shadow_spill #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NUM_SHADOW = 16,
    parameter int unsigned SIDX_W     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spill_req_i,
    input  logic                  restore_req_i,
    input  logic [XLEN-1:0]       sp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [SIDX_W-1:0]     shadow_raddr_o,
    input  logic [XLEN-1:0]       shadow_rdata_i,
    ariane_shadow_spill_if.master mem,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [XLEN-1:0]       rf_wdata_o
);
    localparam int unsigned BYTES = XLEN / 8;
    localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(NUM_SHADOW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPILL
`ifdef SHADOW_RESTORE_EN
        ,
        ST_RLOAD,
        ST_RWAIT,
        ST_SPFIX
`endif
    } state_e;

    state_e            state_q;
    logic [SIDX_W-1:0] idx_q;
    logic [XLEN-1:0]   base_q;
    logic              done_q;
    logic [XLEN-1:0]   slot_addr;
    logic              is_spill;

    assign slot_addr = base_q + (XLEN'(idx_q) * XLEN'(BYTES));
    assign is_spill  = (state_q == ST_SPILL);

`ifdef SHADOW_RESTORE_EN
    localparam logic [XLEN-1:0] FRAME = XLEN'(NUM_SHADOW * BYTES);

    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic            is_rload;

    // Shadow slot -> architectural caller-saved register.
    function automatic logic [4:0] arch_reg(input logic [SIDX_W-1:0] i);
        if (i == '0)        return 5'd1;
        else if (i < 4'd4)  return 5'(i) + 5'd4;
        else if (i < 4'd12) return 5'(i) + 5'd6;
        else                return 5'(i) + 5'd16;
    endfunction

    assign is_rload   = (state_q == ST_RLOAD);
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
`else
    logic unused_restore;
    assign unused_restore = ^{restore_req_i, mem.rsp_valid, mem.rsp_rdata};
    assign rf_we_o    = 1'b0;
    assign rf_waddr_o = '0;
    assign rf_wdata_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
`ifdef SHADOW_RESTORE_EN
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef SHADOW_RESTORE_EN
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (spill_req_i) begin
                        base_q  <= sp_i;
                        idx_q   <= '0;
                        state_q <= ST_SPILL;
`ifdef SHADOW_RESTORE_EN
                    end else if (restore_req_i) begin
                        base_q  <= sp_i;
                        idx_q   <= '0;
                        state_q <= ST_RLOAD;
`endif
                    end
                end
                ST_SPILL: begin
                    if (mem.req_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q + SIDX_W'(1);
                        end
                    end
                end
`ifdef SHADOW_RESTORE_EN
                ST_RLOAD: begin
                    if (mem.req_ready) state_q <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (mem.rsp_valid) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= arch_reg(idx_q);
                        rf_wdata_q <= mem.rsp_rdata;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_SPFIX;
                        end else begin
                            idx_q   <= idx_q + SIDX_W'(1);
                            state_q <= ST_RLOAD;
                        end
                    end
                end
                // One cycle after the x31 write so the sp pop lands on its own regfile write slot.
                ST_SPFIX: begin
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= 5'd2;
                    rf_wdata_q <= base_q + FRAME;
                    done_q     <= 1'b1;
                    idx_q      <= '0;
                    state_q    <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_q;
    assign shadow_raddr_o = is_spill ? idx_q : '0;
    assign mem.req_we     = is_spill;
    assign mem.req_wdata  = is_spill ? shadow_rdata_i : '0;
`ifdef SHADOW_RESTORE_EN
    assign mem.req_valid  = is_spill | is_rload;
    assign mem.req_addr   = (is_spill | is_rload) ? slot_addr : '0;
`else
    assign mem.req_valid  = is_spill;
    assign mem.req_addr   = is_spill ? slot_addr : '0;
`endif
endmodule

// File: tb/tb_ariane_shadow_spill.sv
// Directed bench for ariane_shadow_spill; restore checks compile in when SHADOW_RESTORE_EN is defined.
module tb_ariane_shadow_spill;
    logic        clk = 1'b0;
    logic        rst;
    logic        spill_req;
    logic        restore_req;
    logic [63:0] sp;
    logic        busy;
    logic        done;
    logic [3:0]  shadow_raddr;
    logic [63:0] shadow_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    ariane_shadow_spill_if #(.XLEN(64)) mem_if ();

    ariane_shadow_spill #(.XLEN(64), .NUM_SHADOW(16), .SIDX_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .spill_req_i    (spill_req),
        .restore_req_i  (restore_req),
        .sp_i           (sp),
        .busy_o         (busy),
        .done_o         (done),
        .shadow_raddr_o (shadow_raddr),
        .shadow_rdata_i (shadow_rdata),
        .mem            (mem_if.master),
        .rf_we_o        (rf_we),
        .rf_waddr_o     (rf_waddr),
        .rf_wdata_o     (rf_wdata)
    );

    always #5 clk = ~clk;

    // Shadow bank contents: entry i holds 0xA0 + i.
    assign shadow_rdata = 64'hA0 + 64'(shadow_raddr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},  64'(busy), 64'd0);
        check({tag, " done"},  64'(done), 64'd0);
        check({tag, " valid"}, 64'(mem_if.req_valid), 64'd0);
        check({tag, " we"},    64'(mem_if.req_we), 64'd0);
        check({tag, " addr"},  mem_if.req_addr, 64'd0);
        check({tag, " wdata"}, mem_if.req_wdata, 64'd0);
        check({tag, " raddr"}, 64'(shadow_raddr), 64'd0);
        check({tag, " rf_we"}, 64'(rf_we), 64'd0);
    endtask

    // Full spill with ready held high; optionally asserts restore alongside the request
    // and again mid-sequence, neither of which may have any effect.
    task automatic spill_full(input string tag, input logic [63:0] base, input logic also_restore);
        sp          = base;
        spill_req   = 1'b1;
        restore_req = also_restore;
        mem_if.req_ready = 1'b1;
        tick();
        spill_req   = 1'b0;
        restore_req = 1'b0;
        sp          = 64'd0;
        for (int i = 0; i < 16; i++) begin
            check({tag, " busy"},  64'(busy), 64'd1);
            check({tag, " done"},  64'(done), 64'd0);
            check({tag, " valid"}, 64'(mem_if.req_valid), 64'd1);
            check({tag, " we"},    64'(mem_if.req_we), 64'd1);
            check({tag, " addr"},  mem_if.req_addr, base + 64'(i) * 64'd8);
            check({tag, " wdata"}, mem_if.req_wdata, 64'hA0 + 64'(i));
            check({tag, " raddr"}, 64'(shadow_raddr), 64'(i));
            check({tag, " rf_we"}, 64'(rf_we), 64'd0);
            if (also_restore && i == 8) restore_req = 1'b1;
            tick();
            restore_req = 1'b0;
        end
        check({tag, " done pulse"}, 64'(done), 64'd1);
        check({tag, " busy end"},   64'(busy), 64'd0);
        check({tag, " valid end"},  64'(mem_if.req_valid), 64'd0);
        tick();
        check_quiet({tag, " after"});
    endtask

`ifdef SHADOW_RESTORE_EN
    logic [4:0] arch_map [16] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13,
                                  5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31};
`endif

    initial begin
        rst = 1'b1;
        spill_req = 1'b0;
        restore_req = 1'b0;
        sp = 64'd0;
        mem_if.req_ready = 1'b0;
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_rdata = 64'd0;
        tick();
        tick();
        rst = 1'b0;
        check_quiet("reset");
        tick();
        check_quiet("idle");

        // Test 1: basic spill
        spill_full("spill", 64'h8000_0F80, 1'b0);

        // Test 2: back-pressure on entry 5
        sp = 64'h0000_2000;
        spill_req = 1'b1;
        mem_if.req_ready = 1'b1;
        tick();
        spill_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                mem_if.req_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check("stall valid", 64'(mem_if.req_valid), 64'd1);
                    check("stall addr",  mem_if.req_addr, 64'h0000_2028);
                    check("stall wdata", mem_if.req_wdata, 64'hA5);
                    check("stall raddr", 64'(shadow_raddr), 64'd5);
                    tick();
                end
                mem_if.req_ready = 1'b1;
            end
            check("bp addr",  mem_if.req_addr, 64'h0000_2000 + 64'(i) * 64'd8);
            check("bp raddr", 64'(shadow_raddr), 64'(i));
            check("bp done",  64'(done), 64'd0);
            tick();
        end
        check("bp done pulse", 64'(done), 64'd1);
        tick();

        // Test 4: simultaneous requests and restore during spill
        spill_full("both", 64'h8000_0F80, 1'b1);

        // Address wrap is silent modulo 2^64
        spill_full("wrap", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);

        // Test 5a: reset after 7 stores
        sp = 64'h8000_0F80;
        spill_req = 1'b1;
        mem_if.req_ready = 1'b1;
        tick();
        spill_req = 1'b0;
        repeat (7) tick();
        check("pre-rst raddr", 64'(shadow_raddr), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("rst spill");
        tick();
        check_quiet("rst spill+1");

`ifdef SHADOW_RESTORE_EN
        // Test 3: restore
        sp = 64'h8000_0F80;
        restore_req = 1'b1;
        mem_if.req_ready = 1'b1;
        tick();
        restore_req = 1'b0;
        sp = 64'd0;
        check("rs rf_we start", 64'(rf_we), 64'd0);
        for (int i = 0; i < 16; i++) begin
            check("rs busy",  64'(busy), 64'd1);
            check("rs valid", 64'(mem_if.req_valid), 64'd1);
            check("rs we",    64'(mem_if.req_we), 64'd0);
            check("rs addr",  mem_if.req_addr, 64'h8000_0F80 + 64'(i) * 64'd8);
            check("rs wdata", mem_if.req_wdata, 64'd0);
            tick();
            check("rs wait valid", 64'(mem_if.req_valid), 64'd0);
            check("rs wait rf_we", 64'(rf_we), 64'd0);
            mem_if.rsp_valid = 1'b1;
            mem_if.rsp_rdata = 64'h100 + 64'(i);
            tick();
            mem_if.rsp_valid = 1'b0;
            mem_if.rsp_rdata = 64'd0;
            check("rs rf_we",    64'(rf_we), 64'd1);
            check("rs rf_waddr", 64'(rf_waddr), 64'(arch_map[i]));
            check("rs rf_wdata", rf_wdata, 64'h100 + 64'(i));
        end
        check("spfix busy", 64'(busy), 64'd1);
        check("spfix done", 64'(done), 64'd0);
        tick();
        check("sp rf_we",    64'(rf_we), 64'd1);
        check("sp rf_waddr", 64'(rf_waddr), 64'd2);
        check("sp rf_wdata", rf_wdata, 64'h8000_1000);
        check("sp done",     64'(done), 64'd1);
        check("sp busy",     64'(busy), 64'd0);
        tick();
        check_quiet("rs after");

        // Test 5b: reset mid-RWAIT, late response ignored
        sp = 64'h8000_0F80;
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        tick();
        check("rwait valid", 64'(mem_if.req_valid), 64'd0);
        check("rwait busy",  64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("rst rwait");
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_rdata = 64'hDEAD;
        tick();
        mem_if.rsp_valid = 1'b0;
        check_quiet("late rsp");
`else
        // Test 6: restore ignored without the restore path
        sp = 64'h8000_0F80;
        restore_req = 1'b1;
        mem_if.req_ready = 1'b1;
        tick();
        restore_req = 1'b0;
        check_quiet("norestore");
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_rdata = 64'h1234;
        tick();
        mem_if.rsp_valid = 1'b0;
        check_quiet("norestore+1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
